fpu_op_sequencer: RTL and testbench
===================================

Name: fpu_op_sequencer

Overview:
- Issue/capture stage between the FP register-read stage and the combinational AddSubFPU, MulFPU and DivFPU units.
- Accepts one FP op per handshake and holds the operands stable on the unit inputs for a programmed multicycle-path latency.
- Captures the selected unit result, or an overriding special-case result, with its fflags, and presents it to writeback with a valid/ready handshake.

Parameters:
- ADD_CYCLES, 2, cycles from acceptance to result capture for FADD/FSUB (min 1)
- MUL_CYCLES, 2, same for FMUL (min 1)
- DIV_CYCLES, 4, same for FDIV (min 1)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  sequencer can accept
- in_op  in  2  00 FADD, 01 FSUB, 10 FMUL, 11 FDIV
- in_a  in  32  IEEE-754 single, rs1 value
- in_b  in  32  IEEE-754 single, rs2 value
- in_rd  in  5  destination register tag
- op_a  out  32  operand A to all three units
- op_b  out  32  operand B to all three units (sign-flipped for FSUB)
- add_result  in  32  AddSubFPU result (A+B)
- mul_result  in  32  MulFPU result
- div_result  in  32  DivFPU result
- out_valid  out  1  result valid
- out_ready  in  1  writeback accepts
- out_result  out  32  captured result
- out_rd  out  5  tag of captured op
- out_flags  out  5  fflags {NV,DZ,OF,UF,NX}

Behaviour:
- Reset values: state IDLE, in_ready=1, out_valid=0, out_result=0, out_rd=0, out_flags=0, op_a=0, op_b=0, count=0.
- Reset has priority over all events, including mid-operation; an in-flight op is discarded and produces no out_valid.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch op, a, b and rd; load count=LAT-1, where LAT is the per-op parameter; go to BUSY.
  - BUSY: in_ready=0. Count decrements each cycle. When count==0, capture the result into out_* and set out_valid=1; go to DONE.
  - DONE: in_ready=0 and out_* held stable. On out_valid&&out_ready, out_valid=0 and go to IDLE. There is no same-cycle turnaround, so the next acceptance is at the earliest one cycle after the pop.
- Latency: out_valid rises on the edge exactly LAT cycles after the acceptance edge.
- in_valid while not IDLE is ignored (no accept); the requester must hold it.
- op_a/op_b come from registers, are stable for the whole BUSY/DONE period, and change only on acceptance.
  - op_b = in_b with bit31 inverted for FSUB.
  - op_b = in_b unchanged otherwise.
- Result select at capture: ADD/SUB uses add_result, MUL uses mul_result, DIV uses div_result, unless overridden by a special case.
- Special cases are computed on the latched operands, with the effective b used for SUB.
  - Zero means exp==0; denormals are flushed to zero.
  - s = a.sign XOR b.sign.
  - Overrides keep the same latency as the normal path.
- Special-case priority, first match wins:
  1. Any operand exp==255 (any op): result 0x7FC00000, flags 10000.
  2. FDIV, a zero and b zero: result 0x7FC00000, flags 10000.
  3. FDIV, b zero: result {s,8'hFF,23'h0}, flags 01000.
  4. FDIV, a zero: result {s,31'h0}, flags 00000.
  5. FMUL, either operand zero: result {s,31'h0}, flags 00000.
  6. Otherwise the unit result with flags 00000. OF, UF and NX are always 0.
- The unit results are treated as a multicycle combinational path. The block only samples them at the capture edge.

Decomposition:
- Shared package fpu_pkg:
  - op encodings: OP_FADD, OP_FSUB, OP_FMUL, OP_FDIV
  - CANON_NAN=32'h7FC00000, POS_INF=32'h7F800000
  - fflags bit indices: FF_NV=4, FF_DZ=3, FF_OF=2, FF_UF=1, FF_NX=0
  - state encodings
- One combinational sub-module, fpu_special_case:
  - inputs: op, a, effective b
  - outputs: override_en, override_value, flags
- The sequencer owns the FSM, the counter and the output registers.

Test Plan:
- FDIV 4.2/3.2 (a=0x40866666, b=0x404CCCCD, rd=7): out_valid rises exactly 4 cycles after acceptance; out_result==div_result (~1.3125); out_rd=7; flags=0; op_a/op_b stable throughout.
- FSUB 6.4-0.5 (a=0x40CCCCCD, b=0x3F000000): op_b==0xBF000000 during BUSY; result==add_result (~5.9); valid after 2 cycles.
- FDIV cases:
  - 2.0/0 (0x40000000/0x00000000): result 0x7F800000, flags 01000.
  - -1.0/0: result 0xFF800000, flags 01000.
  - 0/0: result 0x7FC00000, flags 10000.
- FMUL with a=0x7F800000 and b=0x3F800000: result 0x7FC00000, NV. FMUL -0.5*0: result 0x80000000, flags 0.
- Backpressure: out_ready low for 3 cycles after out_valid, with a second in_valid held high.
  - out_* stay stable and in_ready stays 0.
  - The second op is accepted only one cycle after the pop.
- Reset mid-FDIV (rst asserted 2 cycles after acceptance): out_valid never asserts; after rst deasserts, in_ready=1 and a new op completes normally.

Source files
------------

// File: rtl/fpu_pkg.sv
// fpu_pkg: op, state and fflags encodings shared by the FP issue/capture stage.
package fpu_pkg;
    typedef enum logic [1:0] {OP_FADD = 2'b00, OP_FSUB = 2'b01, OP_FMUL = 2'b10, OP_FDIV = 2'b11} op_e;
    typedef enum logic [1:0] {ST_IDLE = 2'b00, ST_BUSY = 2'b01, ST_DONE = 2'b10} state_e;
    localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF = 32'h7F80_0000;
    localparam int FF_NV = 4;
    localparam int FF_DZ = 3;
    localparam int FF_OF = 2;
    localparam int FF_UF = 1;
    localparam int FF_NX = 0;
    function automatic logic is_zero(input logic [31:0] x);
        return x[30:23] == 8'h00;
    endfunction
    function automatic logic is_inf_nan(input logic [31:0] x);
        return x[30:23] == 8'hFF;
    endfunction
endpackage

// File: rtl/fpu_op_sequencer_if.sv
// fpu_op_sequencer_if: request, unit operand/result and writeback signals of the sequencer.
interface fpu_op_sequencer_if;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [4:0]  in_rd;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] add_result;
    logic [31:0] mul_result;
    logic [31:0] div_result;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic [4:0]  out_flags;
    modport slave (
        input  in_valid, in_op, in_a, in_b, in_rd, add_result, mul_result, div_result, out_ready,
        output in_ready, op_a, op_b, out_valid, out_result, out_rd, out_flags
    );
    modport master (
        output in_valid, in_op, in_a, in_b, in_rd, add_result, mul_result, div_result, out_ready,
        input  in_ready, op_a, op_b, out_valid, out_result, out_rd, out_flags
    );
endinterface

// File: rtl/fpu_special_case.sv
// fpu_special_case: NaN/Inf and zero-operand overrides with their fflags, on latched operands.
module fpu_special_case
    import fpu_pkg::*;
(
    input  op_e         op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        override_en,
    output logic [31:0] override_value,
    output logic [4:0]  flags
);
    logic s, az, bz, any_special, is_div, is_mul, invalid;
    always_comb begin
        s = a[31] ^ b[31];
        az = is_zero(a);
        bz = is_zero(b);
        any_special = is_inf_nan(a) || is_inf_nan(b);
        is_div = op == OP_FDIV;
        is_mul = op == OP_FMUL;
        invalid = any_special || (is_div && az && bz);
        override_en = any_special || ((is_div || is_mul) && (az || bz));
        override_value = invalid ? CANON_NAN : (is_div && bz) ? {s, POS_INF[30:0]} : {s, 31'h0};
        flags = invalid ? 5'(1 << FF_NV) : (is_div && bz) ? 5'(1 << FF_DZ) : 5'h00;
    end
endmodule

// File: rtl/fpu_op_sequencer.sv
// fpu_op_sequencer: holds operands on the FP units for a fixed multicycle latency, then captures the result.
module fpu_op_sequencer
    import fpu_pkg::*;
#(
    parameter int ADD_CYCLES = 2,
    parameter int MUL_CYCLES = 2,
    parameter int DIV_CYCLES = 4
) (
    input logic clk,
    input logic rst,
    fpu_op_sequencer_if.slave io
);
    localparam int MAX_AM = ADD_CYCLES > MUL_CYCLES ? ADD_CYCLES : MUL_CYCLES;
    localparam int MAX_LAT = MAX_AM > DIV_CYCLES ? MAX_AM : DIV_CYCLES;
    localparam int CW = $clog2(MAX_LAT + 1);
    state_e      state_q, state_d;
    op_e         op_q, op_d, in_op;
    logic [CW-1:0] count_q, count_d, lat_m1;
    logic [31:0] op_a_q, op_a_d, op_b_q, op_b_d, unit_res;
    logic [31:0] out_result_q, out_result_d, sc_val;
    logic [4:0]  rd_q, rd_d, out_rd_q, out_rd_d, out_flags_q, out_flags_d, sc_flags;
    logic        out_valid_q, out_valid_d, sc_en;
    // Overrides are evaluated on the registered operands, so op_b already carries the FSUB sign flip.
    fpu_special_case u_sc (
        .op(op_q),
        .a(op_a_q),
        .b(op_b_q),
        .override_en(sc_en),
        .override_value(sc_val),
        .flags(sc_flags)
    );
    always_comb begin
        in_op = op_e'(io.in_op);
        lat_m1 = in_op == OP_FDIV ? CW'(DIV_CYCLES - 1) : in_op == OP_FMUL ? CW'(MUL_CYCLES - 1) : CW'(ADD_CYCLES - 1);
        unit_res = op_q == OP_FDIV ? io.div_result : op_q == OP_FMUL ? io.mul_result : io.add_result;
        state_d = state_q;
        op_d = op_q;
        count_d = count_q;
        op_a_d = op_a_q;
        op_b_d = op_b_q;
        rd_d = rd_q;
        out_valid_d = out_valid_q;
        out_result_d = out_result_q;
        out_rd_d = out_rd_q;
        out_flags_d = out_flags_q;
        if (state_q == ST_IDLE && io.in_valid) begin
            state_d = ST_BUSY;
            op_d = in_op;
            count_d = lat_m1;
            op_a_d = io.in_a;
            op_b_d = {io.in_b[31] ^ (in_op == OP_FSUB), io.in_b[30:0]};
            rd_d = io.in_rd;
        end else if (state_q == ST_BUSY) begin
            count_d = count_q - 1'b1;
            if (count_q == '0) begin
                state_d = ST_DONE;
                count_d = '0;
                out_valid_d = 1'b1;
                out_result_d = sc_en ? sc_val : unit_res;
                out_flags_d = sc_en ? sc_flags : 5'h00;
                out_rd_d = rd_q;
            end
        end else if (state_q == ST_DONE && io.out_ready) begin
            state_d = ST_IDLE;
            out_valid_d = 1'b0;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q <= OP_FADD;
            count_q <= '0;
            op_a_q <= '0;
            op_b_q <= '0;
            rd_q <= '0;
            out_valid_q <= 1'b0;
            out_result_q <= '0;
            out_rd_q <= '0;
            out_flags_q <= '0;
        end else begin
            state_q <= state_d;
            op_q <= op_d;
            count_q <= count_d;
            op_a_q <= op_a_d;
            op_b_q <= op_b_d;
            rd_q <= rd_d;
            out_valid_q <= out_valid_d;
            out_result_q <= out_result_d;
            out_rd_q <= out_rd_d;
            out_flags_q <= out_flags_d;
        end
    end
    assign io.in_ready = state_q == ST_IDLE;
    assign io.op_a = op_a_q;
    assign io.op_b = op_b_q;
    assign io.out_valid = out_valid_q;
    assign io.out_result = out_result_q;
    assign io.out_rd = out_rd_q;
    assign io.out_flags = out_flags_q;
endmodule

// File: tb/tb_fpu_op_sequencer.sv
// tb_fpu_op_sequencer: directed and randomized checks of the FP sequencer against a rule-level model.
module tb_fpu_op_sequencer;
    localparam int ADD_LAT = 2;
    localparam int MUL_LAT = 2;
    localparam int DIV_LAT = 4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    logic [31:0] cur_a, cur_b;
    logic [36:0] cur_exp;
    logic [4:0]  cur_rd;
    int          cur_lat;
    fpu_op_sequencer_if bus ();
    fpu_op_sequencer #(.ADD_CYCLES(ADD_LAT), .MUL_CYCLES(MUL_LAT), .DIV_CYCLES(DIV_LAT)) dut (
        .clk(clk),
        .rst(rst),
        .io(bus.slave)
    );
    always #5 clk = ~clk;
    // Stand-in combinational units: arbitrary but deterministic functions of the presented operands.
    function automatic logic [31:0] unit_fn(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op == 2'd3) return a ^ {b[15:0], b[31:16]};
        if (op == 2'd2) return a * b;
        return a + b;
    endfunction
    assign bus.add_result = unit_fn(2'd0, bus.op_a, bus.op_b);
    assign bus.mul_result = unit_fn(2'd2, bus.op_a, bus.op_b);
    assign bus.div_result = unit_fn(2'd3, bus.op_a, bus.op_b);
    function automatic logic [31:0] eff_b(input logic [1:0] op, input logic [31:0] b);
        return (op == 2'd1) ? (b ^ 32'h8000_0000) : b;
    endfunction
    // Returns {flags, result} following the special-case priority list.
    function automatic logic [36:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] eb;
        logic s, az, bz;
        eb = eff_b(op, b);
        s = a[31] ^ eb[31];
        az = a[30:23] == 0;
        bz = eb[30:23] == 0;
        if (a[30:23] == 8'hFF || eb[30:23] == 8'hFF) return {5'b10000, 32'h7FC0_0000};
        if (op == 2'd3 && az && bz) return {5'b10000, 32'h7FC0_0000};
        if (op == 2'd3 && bz) return {5'b01000, s, 8'hFF, 23'h0};
        if (op == 2'd3 && az) return {5'b00000, s, 31'h0};
        if (op == 2'd2 && (az || bz)) return {5'b00000, s, 31'h0};
        return {5'b00000, unit_fn(op, a, eb)};
    endfunction
    function automatic int lat_of(input logic [1:0] op);
        return op == 2'd3 ? DIV_LAT : op == 2'd2 ? MUL_LAT : ADD_LAT;
    endfunction
    function automatic logic [31:0] rand_fp();
        logic [31:0] v;
        int cls;
        v = $urandom;
        cls = $urandom_range(0, 5);
        if (cls == 0) v[30:23] = 8'h00;
        if (cls == 1) v[30:23] = 8'hFF;
        return v;
    endfunction
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        int n;
        bus.in_valid = 1'b1;
        bus.in_op = op;
        bus.in_a = a;
        bus.in_b = b;
        bus.in_rd = rd;
        cur_a = a;
        cur_b = eff_b(op, b);
        cur_exp = model(op, a, b);
        cur_rd = rd;
        cur_lat = lat_of(op);
        n = 0;
        while (!bus.in_ready && n < 40) begin
            tick();
            n++;
        end
        chk("accept_timeout", 64'(n < 40), 64'd1);
        tick();
        bus.in_valid = 1'b0;
        chk("busy_in_ready", 64'(bus.in_ready), 64'd0);
        chk("latched_op_a", 64'(bus.op_a), 64'(cur_a));
        chk("latched_op_b", 64'(bus.op_b), 64'(cur_b));
    endtask
    task automatic wait_result();
        int c;
        c = 0;
        while (!bus.out_valid && c < 40) begin
            chk("hold_op_a", 64'(bus.op_a), 64'(cur_a));
            chk("hold_op_b", 64'(bus.op_b), 64'(cur_b));
            tick();
            c++;
        end
        chk("latency", 64'(c), 64'(cur_lat));
        chk("out_valid", 64'(bus.out_valid), 64'd1);
        chk("out_result", 64'(bus.out_result), 64'(cur_exp[31:0]));
        chk("out_flags", 64'(bus.out_flags), 64'(cur_exp[36:32]));
        chk("out_rd", 64'(bus.out_rd), 64'(cur_rd));
    endtask
    task automatic pop(input int d);
        bus.out_ready = 1'b0;
        repeat (d) begin
            tick();
            chk("stall_valid", 64'(bus.out_valid), 64'd1);
            chk("stall_result", 64'(bus.out_result), 64'(cur_exp[31:0]));
            chk("stall_flags", 64'(bus.out_flags), 64'(cur_exp[36:32]));
            chk("stall_rd", 64'(bus.out_rd), 64'(cur_rd));
            chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
            chk("stall_op_a", 64'(bus.op_a), 64'(cur_a));
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("pop_valid", 64'(bus.out_valid), 64'd0);
        chk("pop_in_ready", 64'(bus.in_ready), 64'd1);
    endtask
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd, input int d);
        start_op(op, a, b, rd);
        wait_result();
        pop(d);
    endtask
    initial begin
        bus.in_valid = 1'b0;
        bus.in_op = 2'd0;
        bus.in_a = '0;
        bus.in_b = '0;
        bus.in_rd = '0;
        bus.out_ready = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_result", 64'(bus.out_result), 64'd0);
        chk("rst_out_rd", 64'(bus.out_rd), 64'd0);
        chk("rst_out_flags", 64'(bus.out_flags), 64'd0);
        chk("rst_op_a", 64'(bus.op_a), 64'd0);
        chk("rst_op_b", 64'(bus.op_b), 64'd0);
        rst = 1'b0;
        tick();
        run_op(2'd3, 32'h4086_6666, 32'h404C_CCCD, 5'd7, 0);
        start_op(2'd1, 32'h40CC_CCCD, 32'h3F00_0000, 5'd3);
        chk("fsub_op_b", 64'(bus.op_b), 64'h0000_0000_BF00_0000);
        wait_result();
        pop(1);
        run_op(2'd3, 32'h4000_0000, 32'h0000_0000, 5'd1, 0);
        chk("div_pos_by_zero", 64'({cur_exp[36:32], cur_exp[31:0]}), 64'({5'b01000, 32'h7F80_0000}));
        run_op(2'd3, 32'hBF80_0000, 32'h0000_0000, 5'd2, 0);
        run_op(2'd3, 32'h0000_0000, 32'h0000_0000, 5'd4, 0);
        run_op(2'd2, 32'h7F80_0000, 32'h3F80_0000, 5'd5, 0);
        run_op(2'd2, 32'hBF00_0000, 32'h0000_0000, 5'd6, 0);
        start_op(2'd0, 32'h3F80_0000, 32'h4000_0000, 5'd8);
        wait_result();
        bus.in_valid = 1'b1;
        bus.in_op = 2'd2;
        bus.in_a = 32'h4040_0000;
        bus.in_b = 32'h4080_0000;
        bus.in_rd = 5'd9;
        pop(3);
        chk("no_early_accept", 64'(bus.op_a), 64'h0000_0000_3F80_0000);
        start_op(2'd2, 32'h4040_0000, 32'h4080_0000, 5'd9);
        wait_result();
        pop(0);
        start_op(2'd3, 32'h4086_6666, 32'h404C_CCCD, 5'd10);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("midrst_op_a", 64'(bus.op_a), 64'd0);
        chk("midrst_out_result", 64'(bus.out_result), 64'd0);
        repeat (6) begin
            chk("midrst_no_valid", 64'(bus.out_valid), 64'd0);
            tick();
        end
        run_op(2'd0, 32'h4120_0000, 32'h3F80_0000, 5'd11, 1);
        for (int i = 0; i < 60; i++) begin
            run_op(2'($urandom_range(0, 3)), rand_fp(), rand_fp(), 5'($urandom), $urandom_range(0, 2));
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
